// File: rtl/seg_bcd_conv_if.sv
// Display word in, packed BCD digits and status out.
// master drives data_in; slave returns bcd_out, overflow, valid, busy, done.
interface seg_bcd_conv_if;
  logic [31:0] data_in;
  logic [15:0] bcd_out;
  logic        overflow;
  logic        valid;
  logic        busy;
  logic        done;

  modport master (
    output data_in,
    input  bcd_out,
    input  overflow,
    input  valid,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    output bcd_out,
    output overflow,
    output valid,
    output busy,
    output done
  );
endinterface

// File: rtl/seg_bcd_conv.sv
// Iterative double-dabble binary-to-BCD converter for the 7-seg display.
// Ports: clk, rst (async active-low), bus (slave: data_in in; bcd/status out).
module seg_bcd_conv #(
  parameter int CONV_BITS = 16
) (
  input  logic          clk,
  input  logic          rst,
  seg_bcd_conv_if.slave bus
);

  localparam int DIGITS = (CONV_BITS * 301) / 1000 + 1;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(CONV_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CONV_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic [CONV_BITS-1:0] shift_reg;
  logic [CONV_BITS-1:0] last_val;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     adj;
  logic [CNT_W-1:0]     cnt;
  logic                 force_cnv;
  logic                 unused_hi;

  assign unused_hi = ^bus.data_in[31:CONV_BITS];

  // +3 on every nibble >= 5, all from pre-shift values
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shift_reg    <= '0;
      last_val     <= '0;
      scratch      <= '0;
      cnt          <= '0;
      force_cnv    <= 1'b1;
      bus.bcd_out  <= '0;
      bus.overflow <= 1'b0;
      bus.valid    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (force_cnv ||
              bus.data_in[CONV_BITS-1:0] != last_val) begin
            shift_reg <= bus.data_in[CONV_BITS-1:0];
            last_val  <= bus.data_in[CONV_BITS-1:0];
            scratch   <= '0;
            cnt       <= '0;
            force_cnv <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shift_reg} <= {adj, shift_reg} << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          // a non-zero fifth digit means the value exceeded 9999
          if (scratch[BCD_W-1:16] != '0) begin
            bus.bcd_out  <= 16'h9999;
            bus.overflow <= 1'b1;
          end else begin
            bus.bcd_out  <= scratch[15:0];
            bus.overflow <= 1'b0;
          end
          bus.valid <= 1'b1;
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
